// File: rtl/reservation_station.sv
// Tomasulo reservation station feeding a single functional unit.
// Holds dispatched micro-ops until both operands are known. Missing operands
// are captured from the ROB broadcast bus. At most one op is in flight at the FU.
// Optional build macro: RS_PERF_CNT_EN adds three saturating 16-bit activity
// counters (accepted dispatches, issues, cycles stalled on a full station).
module reservation_station #(
    parameter int NUM_ENTRIES  = 8,
    parameter int RS_IDX_SIZE  = $clog2(NUM_ENTRIES),
    parameter int GPR_SIZE     = 64,
    parameter int GPR_IDX_SIZE = 5,
    parameter int ROB_IDX_SIZE = 4
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_dispatch_valid,
    input  logic                    in_op1_valid,
    input  logic                    in_op2_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_op1_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_op2_rob_index,
    input  logic [GPR_SIZE-1:0]     in_op1_value,
    input  logic [GPR_SIZE-1:0]     in_op2_value,
    input  logic [GPR_IDX_SIZE-1:0] in_dst,
    input  logic [ROB_IDX_SIZE-1:0] in_dst_rob_idx,
    input  logic                    in_set_nzcv,
    input  logic                    in_rob_broadcast_done,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_broadcast_index,
    input  logic [GPR_SIZE-1:0]     in_rob_broadcast_val,
    input  logic                    in_rob_is_mispred,
    input  logic                    in_fu_ready,
    input  logic                    in_fu_done,
    output logic [RS_IDX_SIZE:0]    out_ready_index,
    output logic [GPR_SIZE-1:0]     out_op1_value,
    output logic [GPR_SIZE-1:0]     out_op2_value,
    output logic [GPR_IDX_SIZE-1:0] out_dst,
    output logic [ROB_IDX_SIZE-1:0] out_dst_rob_idx,
    output logic                    out_set_nzcv,
    output logic                    out_full
`ifdef RS_PERF_CNT_EN
    ,
    output logic [15:0]             out_dispatch_cnt,
    output logic [15:0]             out_issue_cnt,
    output logic [15:0]             out_full_stall_cnt
`endif
);

    // Per-slot state
    logic [NUM_ENTRIES-1:0]  busy_r;
    logic [NUM_ENTRIES-1:0]  issued_r;
    logic [NUM_ENTRIES-1:0]  op1_valid_r;
    logic [NUM_ENTRIES-1:0]  op2_valid_r;
    logic [ROB_IDX_SIZE-1:0] op1_tag_r   [NUM_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] op2_tag_r   [NUM_ENTRIES];
    logic [GPR_SIZE-1:0]     op1_val_r   [NUM_ENTRIES];
    logic [GPR_SIZE-1:0]     op2_val_r   [NUM_ENTRIES];
    logic [GPR_IDX_SIZE-1:0] dst_r       [NUM_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] dst_rob_r   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  nzcv_r;

    // Combinational helpers
    logic [NUM_ENTRIES-1:0]  ready_s;
    logic [NUM_ENTRIES-1:0]  wake1_s;
    logic [NUM_ENTRIES-1:0]  wake2_s;
    logic [NUM_ENTRIES-1:0]  free_s;
    logic                    any_issued_s;
    logic                    full_s;
    logic                    sel_found_s;
    logic [RS_IDX_SIZE-1:0]  sel_idx_s;
    logic                    alloc_found_s;
    logic [RS_IDX_SIZE-1:0]  alloc_idx_s;
    logic                    issue_fire_s;
    logic                    insert_fire_s;
    logic                    ins_hit1_s;
    logic                    ins_hit2_s;

    assign any_issued_s  = |issued_r;
    assign full_s        = &busy_r;
    assign issue_fire_s  = in_fu_ready & sel_found_s;
    assign insert_fire_s = in_dispatch_valid & ~full_s;
    assign ins_hit1_s    = in_rob_broadcast_done & ~in_op1_valid &
                           (in_op1_rob_index == in_rob_broadcast_index);
    assign ins_hit2_s    = in_rob_broadcast_done & ~in_op2_valid &
                           (in_op2_rob_index == in_rob_broadcast_index);

    // Per-slot readiness, broadcast wakeup matches and allocatable slots
    always_comb begin
        ready_s = '0;
        wake1_s = '0;
        wake2_s = '0;
        free_s  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready_s[i] = busy_r[i] & ~issued_r[i] & op1_valid_r[i] &
                         op2_valid_r[i] & ~any_issued_s;
            wake1_s[i] = in_rob_broadcast_done & busy_r[i] & ~op1_valid_r[i] &
                         (op1_tag_r[i] == in_rob_broadcast_index);
            wake2_s[i] = in_rob_broadcast_done & busy_r[i] & ~op2_valid_r[i] &
                         (op2_tag_r[i] == in_rob_broadcast_index);
            // A slot retiring this cycle may be refilled by a same-cycle insert
            free_s[i]  = ~busy_r[i] | (in_fu_done & issued_r[i]);
        end
    end

    // Lowest-numbered ready slot is presented to the FU
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready_s[i] && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_idx_s   = RS_IDX_SIZE'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-numbered free slot receives the next dispatch
    always_comb begin
        alloc_found_s = 1'b0;
        alloc_idx_s   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_s[i] && !alloc_found_s) begin
                alloc_found_s = 1'b1;
                alloc_idx_s   = RS_IDX_SIZE'(i);
            end else begin
                alloc_found_s = alloc_found_s;
            end
        end
    end

    // Output mux: zeros whenever nothing is selectable
    always_comb begin
        out_ready_index = {sel_found_s, sel_idx_s};
        out_full        = full_s;
        if (sel_found_s) begin
            out_op1_value   = op1_val_r[sel_idx_s];
            out_op2_value   = op2_val_r[sel_idx_s];
            out_dst         = dst_r[sel_idx_s];
            out_dst_rob_idx = dst_rob_r[sel_idx_s];
            out_set_nzcv    = nzcv_r[sel_idx_s];
        end else begin
            out_op1_value   = '0;
            out_op2_value   = '0;
            out_dst         = '0;
            out_dst_rob_idx = '0;
            out_set_nzcv    = 1'b0;
        end
    end

    // Slot state update: flush beats everything; completion precedes refill
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            busy_r      <= '0;
            issued_r    <= '0;
            op1_valid_r <= '0;
            op2_valid_r <= '0;
            nzcv_r      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                op1_tag_r[i] <= '0;
                op2_tag_r[i] <= '0;
                op1_val_r[i] <= '0;
                op2_val_r[i] <= '0;
                dst_r[i]     <= '0;
                dst_rob_r[i] <= '0;
            end
        end else if (in_rob_is_mispred) begin
            busy_r   <= '0;
            issued_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wake1_s[i]) begin
                    op1_valid_r[i] <= 1'b1;
                    op1_val_r[i]   <= in_rob_broadcast_val;
                end
                if (wake2_s[i]) begin
                    op2_valid_r[i] <= 1'b1;
                    op2_val_r[i]   <= in_rob_broadcast_val;
                end
            end
            if (in_fu_done) begin
                busy_r   <= busy_r & ~issued_r;
                issued_r <= '0;
            end
            // Issue only fires when nothing is outstanding, so it never races done
            if (issue_fire_s) begin
                issued_r[sel_idx_s] <= 1'b1;
            end
            if (insert_fire_s) begin
                busy_r[alloc_idx_s]      <= 1'b1;
                issued_r[alloc_idx_s]    <= 1'b0;
                op1_valid_r[alloc_idx_s] <= in_op1_valid | ins_hit1_s;
                op2_valid_r[alloc_idx_s] <= in_op2_valid | ins_hit2_s;
                op1_tag_r[alloc_idx_s]   <= in_op1_rob_index;
                op2_tag_r[alloc_idx_s]   <= in_op2_rob_index;
                op1_val_r[alloc_idx_s]   <= ins_hit1_s ? in_rob_broadcast_val : in_op1_value;
                op2_val_r[alloc_idx_s]   <= ins_hit2_s ? in_rob_broadcast_val : in_op2_value;
                dst_r[alloc_idx_s]       <= in_dst;
                dst_rob_r[alloc_idx_s]   <= in_dst_rob_idx;
                nzcv_r[alloc_idx_s]      <= in_set_nzcv;
            end
        end
    end

`ifdef RS_PERF_CNT_EN
    // Saturating increment for the activity counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Activity counters; flushed cycles do not count as dispatch or issue
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_dispatch_cnt   <= 16'd0;
            out_issue_cnt      <= 16'd0;
            out_full_stall_cnt <= 16'd0;
        end else begin
            if (insert_fire_s && !in_rob_is_mispred) begin
                out_dispatch_cnt <= sat_inc(out_dispatch_cnt);
            end
            if (issue_fire_s && !in_rob_is_mispred) begin
                out_issue_cnt <= sat_inc(out_issue_cnt);
            end
            if (in_dispatch_valid && full_s) begin
                out_full_stall_cnt <= sat_inc(out_full_stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios with literal
// expectations followed by randomized traffic against a slot-list model.
module tb_reservation_station;

    localparam int N  = 8;
    localparam int RI = 3;

    logic        in_clk;
    logic        in_rst;
    logic        in_dispatch_valid;
    logic        in_op1_valid, in_op2_valid;
    logic [3:0]  in_op1_rob_index, in_op2_rob_index;
    logic [63:0] in_op1_value, in_op2_value;
    logic [4:0]  in_dst;
    logic [3:0]  in_dst_rob_idx;
    logic        in_set_nzcv;
    logic        in_rob_broadcast_done;
    logic [3:0]  in_rob_broadcast_index;
    logic [63:0] in_rob_broadcast_val;
    logic        in_rob_is_mispred;
    logic        in_fu_ready, in_fu_done;
    logic [RI:0] out_ready_index;
    logic [63:0] out_op1_value, out_op2_value;
    logic [4:0]  out_dst;
    logic [3:0]  out_dst_rob_idx;
    logic        out_set_nzcv;
    logic        out_full;
`ifdef RS_PERF_CNT_EN
    logic [15:0] out_dispatch_cnt, out_issue_cnt, out_full_stall_cnt;
`endif

    reservation_station dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_dispatch_valid(in_dispatch_valid),
        .in_op1_valid(in_op1_valid), .in_op2_valid(in_op2_valid),
        .in_op1_rob_index(in_op1_rob_index), .in_op2_rob_index(in_op2_rob_index),
        .in_op1_value(in_op1_value), .in_op2_value(in_op2_value),
        .in_dst(in_dst), .in_dst_rob_idx(in_dst_rob_idx), .in_set_nzcv(in_set_nzcv),
        .in_rob_broadcast_done(in_rob_broadcast_done),
        .in_rob_broadcast_index(in_rob_broadcast_index),
        .in_rob_broadcast_val(in_rob_broadcast_val),
        .in_rob_is_mispred(in_rob_is_mispred),
        .in_fu_ready(in_fu_ready), .in_fu_done(in_fu_done),
        .out_ready_index(out_ready_index),
        .out_op1_value(out_op1_value), .out_op2_value(out_op2_value),
        .out_dst(out_dst), .out_dst_rob_idx(out_dst_rob_idx),
        .out_set_nzcv(out_set_nzcv), .out_full(out_full)
`ifdef RS_PERF_CNT_EN
        ,
        .out_dispatch_cnt(out_dispatch_cnt), .out_issue_cnt(out_issue_cnt),
        .out_full_stall_cnt(out_full_stall_cnt)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain list of slots
    logic        m_busy [N];
    logic        m_iss  [N];
    logic        m_v1   [N];
    logic        m_v2   [N];
    logic [3:0]  m_t1   [N];
    logic [3:0]  m_t2   [N];
    logic [63:0] m_x1   [N];
    logic [63:0] m_x2   [N];
    logic [4:0]  m_dst  [N];
    logic [3:0]  m_rob  [N];
    logic        m_nz   [N];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < N; i++)
            if (m_iss[i]) return -1;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_v1[i] && m_v2[i]) return i;
        return -1;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < N; i++)
            if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_iss[i]  = 1'b0;
        end
    endtask

    task automatic check_model();
        int s;
        logic [RI:0] e_idx;
        logic [63:0] e1, e2;
        logic [4:0]  ed;
        logic [3:0]  er;
        logic        en;
        s = model_sel();
        if (s < 0) begin
            e_idx = '0; e1 = '0; e2 = '0; ed = '0; er = '0; en = 1'b0;
        end else begin
            e_idx = {1'b1, 3'(s)};
            e1 = m_x1[s]; e2 = m_x2[s]; ed = m_dst[s]; er = m_rob[s]; en = m_nz[s];
        end
        chk("ready_index", 64'(out_ready_index), 64'(e_idx));
        chk("op1_value", out_op1_value, e1);
        chk("op2_value", out_op2_value, e2);
        chk("dst", 64'(out_dst), 64'(ed));
        chk("dst_rob_idx", 64'(out_dst_rob_idx), 64'(er));
        chk("set_nzcv", 64'(out_set_nzcv), 64'(en));
        chk("full", 64'(out_full), 64'(model_full()));
    endtask

    // Apply the rules for one rising edge using the inputs currently driven
    task automatic model_update();
        int  s;
        bit  full;
        int  k;
        if (in_rob_is_mispred) begin
            model_reset();
        end else begin
            s    = model_sel();
            full = model_full();
            if (in_rob_broadcast_done) begin
                for (int i = 0; i < N; i++) begin
                    if (m_busy[i] && !m_v1[i] && m_t1[i] == in_rob_broadcast_index) begin
                        m_v1[i] = 1'b1; m_x1[i] = in_rob_broadcast_val;
                    end
                    if (m_busy[i] && !m_v2[i] && m_t2[i] == in_rob_broadcast_index) begin
                        m_v2[i] = 1'b1; m_x2[i] = in_rob_broadcast_val;
                    end
                end
            end
            if (in_fu_done) begin
                for (int i = 0; i < N; i++)
                    if (m_iss[i]) begin m_busy[i] = 1'b0; m_iss[i] = 1'b0; end
            end
            if (in_fu_ready && s >= 0) m_iss[s] = 1'b1;
            if (in_dispatch_valid && !full) begin
                k = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) k = i;
                if (k >= 0) begin
                    m_busy[k] = 1'b1; m_iss[k] = 1'b0;
                    m_t1[k] = in_op1_rob_index; m_t2[k] = in_op2_rob_index;
                    m_v1[k] = in_op1_valid; m_x1[k] = in_op1_value;
                    m_v2[k] = in_op2_valid; m_x2[k] = in_op2_value;
                    if (!in_op1_valid && in_rob_broadcast_done && in_op1_rob_index == in_rob_broadcast_index) begin
                        m_v1[k] = 1'b1; m_x1[k] = in_rob_broadcast_val;
                    end
                    if (!in_op2_valid && in_rob_broadcast_done && in_op2_rob_index == in_rob_broadcast_index) begin
                        m_v2[k] = 1'b1; m_x2[k] = in_rob_broadcast_val;
                    end
                    m_dst[k] = in_dst; m_rob[k] = in_dst_rob_idx; m_nz[k] = in_set_nzcv;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        in_dispatch_valid = 1'b0; in_op1_valid = 1'b0; in_op2_valid = 1'b0;
        in_op1_rob_index = '0; in_op2_rob_index = '0;
        in_op1_value = '0; in_op2_value = '0; in_dst = '0; in_dst_rob_idx = '0;
        in_set_nzcv = 1'b0; in_rob_broadcast_done = 1'b0; in_rob_broadcast_index = '0;
        in_rob_broadcast_val = '0; in_rob_is_mispred = 1'b0;
        in_fu_ready = 1'b0; in_fu_done = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step();
        check_model();
        @(posedge in_clk);
        model_update();
        @(negedge in_clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        in_rst = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge in_clk);
        in_rst = 1'b1;
    endtask

    task automatic drive_insert(input logic v1, input logic [3:0] t1, input logic [63:0] x1,
                                input logic v2, input logic [3:0] t2, input logic [63:0] x2,
                                input logic [4:0] d, input logic [3:0] r);
        in_dispatch_valid = 1'b1;
        in_op1_valid = v1; in_op1_rob_index = t1; in_op1_value = x1;
        in_op2_valid = v2; in_op2_rob_index = t2; in_op2_value = x2;
        in_dst = d; in_dst_rob_idx = r; in_set_nzcv = d[0];
    endtask

    initial begin
        in_rst = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge in_clk);
        do_reset();

        // Basic insert of two present operands
        drive_insert(1'b1, 4'd0, 64'd5, 1'b1, 4'd0, 64'd7, 5'd3, 4'd2);
        step();
        idle_inputs();
        chk("t1_ready_index", 64'(out_ready_index), 64'h8);
        chk("t1_op1", out_op1_value, 64'd5);
        chk("t1_op2", out_op2_value, 64'd7);
        chk("t1_rob", 64'(out_dst_rob_idx), 64'd2);
        step();

        // Pending operand woken by a later broadcast
        do_reset();
        drive_insert(1'b0, 4'd6, 64'd0, 1'b1, 4'd0, 64'd1, 5'd4, 4'd9);
        step();
        idle_inputs();
        step();
        chk("t2_not_ready", 64'(out_ready_index), 64'h0);
        in_rob_broadcast_done = 1'b1; in_rob_broadcast_index = 4'd6; in_rob_broadcast_val = 64'h99;
        step();
        idle_inputs();
        chk("t2_ready_index", 64'(out_ready_index), 64'h8);
        chk("t2_op1", out_op1_value, 64'h99);
        step();

        // Fill all slots, drop a ninth, then drain one
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive_insert(1'b1, 4'd0, 64'(i + 16), 1'b1, 4'd0, 64'(i + 32), 5'(i), 4'(i));
            step();
        end
        chk("t3_full", 64'(out_full), 64'd1);
        drive_insert(1'b1, 4'd0, 64'hDEAD, 1'b1, 4'd0, 64'hBEEF, 5'd31, 4'd15);
        step();
        idle_inputs();
        in_fu_ready = 1'b1;
        step();
        in_fu_ready = 1'b0; in_fu_done = 1'b1;
        step();
        idle_inputs();
        chk("t3_not_full", 64'(out_full), 64'd0);
        chk("t3_next_slot", 64'(out_ready_index), 64'h9);
        step();

        // Issue order and single outstanding issue
        do_reset();
        drive_insert(1'b1, 4'd0, 64'd11, 1'b1, 4'd0, 64'd12, 5'd1, 4'd1);
        step();
        drive_insert(1'b1, 4'd0, 64'd21, 1'b1, 4'd0, 64'd22, 5'd2, 4'd3);
        step();
        idle_inputs();
        in_fu_ready = 1'b1;
        chk("t4_slot0_first", 64'(out_ready_index), 64'h8);
        step();
        chk("t4_held", 64'(out_ready_index), 64'h0);
        step();
        in_fu_done = 1'b1;
        step();
        in_fu_done = 1'b0; in_fu_ready = 1'b0;
        chk("t4_slot1_after", 64'(out_ready_index), 64'h9);
        chk("t4_slot1_op1", out_op1_value, 64'd21);
        step();

        // Flush overrides insert and broadcast
        do_reset();
        drive_insert(1'b0, 4'd3, 64'd0, 1'b1, 4'd0, 64'd2, 5'd5, 4'd5);
        step();
        drive_insert(1'b1, 4'd0, 64'd8, 1'b1, 4'd0, 64'd9, 5'd6, 4'd6);
        in_rob_broadcast_done = 1'b1; in_rob_broadcast_index = 4'd3; in_rob_broadcast_val = 64'h33;
        in_rob_is_mispred = 1'b1;
        step();
        idle_inputs();
        chk("t5_ready_index", 64'(out_ready_index), 64'h0);
        chk("t5_full", 64'(out_full), 64'd0);
        step();

        // Asynchronous reset with three busy slots
        for (int i = 0; i < 3; i++) begin
            drive_insert(1'b1, 4'd0, 64'(i + 100), 1'b1, 4'd0, 64'(i + 200), 5'(i + 1), 4'(i + 1));
            step();
        end
        idle_inputs();
        chk("t6_before", 64'(out_ready_index), 64'h8);
        #2;
        in_rst = 1'b0;
        #1;
        chk("t6_ready_index", 64'(out_ready_index), 64'h0);
        chk("t6_op1", out_op1_value, 64'h0);
        chk("t6_rob", 64'(out_dst_rob_idx), 64'h0);
        model_reset();
        @(negedge in_clk);
        in_rst = 1'b1;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 55) begin
                drive_insert($urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), {$urandom, $urandom},
                             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), {$urandom, $urandom},
                             5'($urandom), 4'($urandom));
            end
            in_rob_broadcast_done  = $urandom_range(0, 99) < 45;
            in_rob_broadcast_index = 4'($urandom_range(0, 8));
            in_rob_broadcast_val   = {$urandom, $urandom};
            in_rob_is_mispred      = $urandom_range(0, 99) < 3;
            in_fu_ready            = $urandom_range(0, 99) < 60;
            in_fu_done             = $urandom_range(0, 99) < 35;
            step();
        end

        idle_inputs();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
